pipelined_addsub: RTL and testbench

//  Parametrised, fully pipelined WIDTH-bit unsigned adder/subtractor with per-transaction add/sub mode.

---
 rtl/pipelined_addsub_pkg.sv | 11 +
 rtl/pipelined_addsub_segment.sv | 18 +
 rtl/pipelined_addsub.sv | 130 +++++++++++++
 tb/tb_pipelined_addsub.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared constants for the segmented add/sub pipeline.
// Every Fp add/sub instance reads its segment count from here, so all of them have the same latency.
package pipelined_addsub_pkg;

   localparam int ADDSUB_SEGS_FP = 4;

   function automatic int seg_width(input int width, input int segs);
      return (segs < 1) ? width : width / segs;
   endfunction

endpackage

// File: rtl/pipelined_addsub_segment.sv
// One carry-ripple segment: {cout, z} = x + (sub ? ~y : y) + cin.
module addsub_segment #(
   parameter int SEG_W = 68
) (
   input  logic [SEG_W-1:0] x,
   input  logic [SEG_W-1:0] y,
   input  logic             sub,
   input  logic             cin,
   output logic [SEG_W-1:0] z,
   output logic             cout
);

   logic [SEG_W-1:0] y_eff;

   assign y_eff     = sub ? ~y : y;
   assign {cout, z} = {1'b0, x} + {1'b0, y_eff} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/sub pipeline. The carry moves one SEG_W segment per stage.
// All stages advance together and hold together when the output is stalled.
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH = 272,
   parameter int SEGS  = ADDSUB_SEGS_FP,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_carry,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SEG_W = seg_width(WIDTH, SEGS);

   if (SEGS < 1) begin : g_bad_segs
      $error("pipelined_addsub: SEGS must be >= 1");
   end else if (WIDTH % SEGS != 0) begin : g_bad_width
      $error("pipelined_addsub: WIDTH must be a multiple of SEGS");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("pipelined_addsub: TAG_W must be >= 1");
   end

   logic            adv;
   logic [SEGS:1]   vld_q;
   logic [SEGS:0]   vld_pipe;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;
   assign vld_pipe = {vld_q, in_valid};

   always_ff @(posedge clk) begin
      if (rst)      vld_q <= '0;
      else if (adv) vld_q <= vld_pipe[SEGS-1:0];
   end

   for (genvar k = 0; k < SEGS; k++) begin : g_stg
      localparam int RW = (k + 1) * SEG_W;
      localparam int PW = (SEGS - 1 - k) * SEG_W;

      logic [SEG_W-1:0] sx, sy, sz;
      logic             cin, cout, s_sub;
      logic [TAG_W-1:0] s_tag;
      logic [RW-1:0]    z_d, z_q;
      logic             c_q;
      logic [TAG_W-1:0] tag_q;

      // Stage 0 takes its segment from the input port; later stages take it from the pending operands.
      if (k == 0) begin : g_src
         assign sx    = in_x[SEG_W-1:0];
         assign sy    = in_y[SEG_W-1:0];
         assign cin   = in_sub;
         assign s_sub = in_sub;
         assign s_tag = in_tag;
         assign z_d   = sz;
      end else begin : g_src
         assign sx    = g_stg[k-1].g_pend.x_q[SEG_W-1:0];
         assign sy    = g_stg[k-1].g_pend.y_q[SEG_W-1:0];
         assign cin   = g_stg[k-1].c_q;
         assign s_sub = g_stg[k-1].g_pend.sub_q;
         assign s_tag = g_stg[k-1].tag_q;
         assign z_d   = {sz, g_stg[k-1].z_q};
      end

      addsub_segment #(.SEG_W(SEG_W)) u_seg (
         .x    (sx),
         .y    (sy),
         .sub  (s_sub),
         .cin  (cin),
         .z    (sz),
         .cout (cout)
      );

      // Data registers load only for valid ops, so the outputs keep their last value through bubbles.
      always_ff @(posedge clk) begin
         if (rst) begin
            z_q   <= '0;
            c_q   <= 1'b0;
            tag_q <= '0;
         end else if (adv && vld_pipe[k]) begin
            z_q   <= z_d;
            c_q   <= cout;
            tag_q <= s_tag;
         end
      end

      if (k < SEGS - 1) begin : g_pend
         logic [PW-1:0] x_d, y_d, x_q, y_q;
         logic          sub_q;

         if (k == 0) begin : g_ld
            assign x_d = in_x[WIDTH-1:SEG_W];
            assign y_d = in_y[WIDTH-1:SEG_W];
         end else begin : g_ld
            assign x_d = g_stg[k-1].g_pend.x_q[PW+SEG_W-1:SEG_W];
            assign y_d = g_stg[k-1].g_pend.y_q[PW+SEG_W-1:SEG_W];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               x_q   <= '0;
               y_q   <= '0;
               sub_q <= 1'b0;
            end else if (adv && vld_pipe[k]) begin
               x_q   <= x_d;
               y_q   <= y_d;
               sub_q <= s_sub;
            end
         end
      end
   end

   assign out_valid = vld_pipe[SEGS];
   assign out_z     = g_stg[SEGS-1].z_q;
   assign out_carry = g_stg[SEGS-1].c_q;
   assign out_tag   = g_stg[SEGS-1].tag_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, SEGS=4): directed cases, backpressure, reset, random stream.
module tb_pipelined_addsub;

   localparam int W = 16;
   localparam int S = 4;
   localparam int T = 8;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, in_sub, out_valid, out_ready, out_carry;
   logic [W-1:0] in_x, in_y, out_z;
   logic [T-1:0] in_tag, out_tag;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         sub;
      logic [T-1:0] tag;
   } op_t;

   typedef struct {
      logic [W-1:0] z;
      logic         c;
      logic [T-1:0] tag;
      int           acc_cyc;
      int           acc_stall;
   } exp_t;

   op_t  pend[$];
   exp_t sb[$];
   int   total = 0, bad = 0, cyc = 0, stalls = 0, run = 0, max_run = 0, pops = 0;
   bit   rand_rdy = 1'b0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(W), .SEGS(S), .TAG_W(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sub    (in_sub),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_carry (out_carry),
      .out_tag   (out_tag)
   );

   function automatic exp_t model(input op_t o);
      exp_t e;
      if (o.sub) begin
         e.z = o.x - o.y;
         e.c = (o.x >= o.y);
      end else begin
         {e.c, e.z} = {1'b0, o.x} + {1'b0, o.y};
      end
      e.tag       = o.tag;
      e.acc_cyc   = 0;
      e.acc_stall = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic drive();
      if (pend.size() != 0) begin
         in_valid = 1'b1;
         in_x     = pend[0].x;
         in_y     = pend[0].y;
         in_sub   = pend[0].sub;
         in_tag   = pend[0].tag;
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub, input logic [T-1:0] tag);
      op_t o;
      o.x = x; o.y = y; o.sub = sub; o.tag = tag;
      pend.push_back(o);
      drive();
   endtask

   // One clock: sample at negedge (scoreboard pop/push), then move inputs just after posedge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      cyc++;
      chk("in_ready", {31'b0, in_ready}, {31'b0, !rst && (!out_valid || out_ready)});
      if (rst) begin
         sb.delete();
      end else if (out_valid && out_ready) begin
         pops++;
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL spurious output: z=%h tag=%h, want no output", out_z, out_tag);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            total += 2;
            assert ({out_z, out_carry, out_tag} === {e.z, e.c, e.tag}) else begin
               bad++;
               $error("FAIL result: got z=%h c=%b tag=%h want z=%h c=%b tag=%h",
                      out_z, out_carry, out_tag, e.z, e.c, e.tag);
            end
            assert (cyc - e.acc_cyc === S + stalls - e.acc_stall) else begin
               bad++;
               $error("FAIL latency: got %0d want %0d", cyc - e.acc_cyc, S + stalls - e.acc_stall);
            end
         end
      end
      if (!rst && out_valid && !out_ready) stalls++;
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (in_valid && in_ready) begin
         e           = model(pend[0]);
         e.acc_cyc   = cyc;
         e.acc_stall = stalls;
         sb.push_back(e);
         void'(pend.pop_front());
      end
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      drive();
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((pend.size() != 0 || sb.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk({name, " drained"}, pend.size() + sb.size(), 0);
   endtask

   task automatic expect_one(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic sub, input logic [T-1:0] tag,
                             input logic [W-1:0] z, input logic c);
      int n = 0;
      send(x, y, sub, tag);
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      chk({name, " latency"}, n, S);
      chk({name, " z"}, {16'b0, out_z}, {16'b0, z});
      chk({name, " carry"}, {31'b0, out_carry}, {31'b0, c});
      chk({name, " tag"}, {24'b0, out_tag}, {24'b0, tag});
      drain(name, 20);
   endtask

   initial begin
      logic [31:0] snap;
      int          n;
      rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", {31'b0, out_valid}, 0);
      chk("rst out_z", {16'b0, out_z}, 0);
      chk("rst out_carry", {31'b0, out_carry}, 0);
      chk("rst out_tag", {24'b0, out_tag}, 0);
      chk("rst in_ready", {31'b0, in_ready}, 0);
      rst = 1'b0;

      expect_one("add seg carry", 16'h00FF, 16'h0001, 1'b0, 8'h5A, 16'h0100, 1'b0);
      expect_one("sub borrow",    16'h0000, 16'h0001, 1'b1, 8'h11, 16'hFFFF, 1'b0);
      expect_one("sub equal",     16'h1234, 16'h1234, 1'b1, 8'h22, 16'h0000, 1'b1);
      expect_one("add wrap",      16'hFFFF, 16'h0001, 1'b0, 8'h33, 16'h0000, 1'b1);

      // 100 back-to-back alternating ops
      max_run = 0;
      for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), i[0], T'(i));
      drain("stream", 400);
      chk("stream valid run", max_run, 100);

      // Backpressure: fill the pipe with one op waiting at the input, stall 5 cycles
      pops = 0;
      out_ready = 1'b0;
      for (int i = 0; i < S + 1; i++) send(W'($urandom), W'($urandom), 1'($urandom), T'(8'hA0 + i));
      n = 0;
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      chk("bp filled", {31'b0, out_valid}, 1);
      snap = {7'b0, out_z, out_carry, out_tag};
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp in_ready", {31'b0, in_ready}, 0);
         chk("bp out_valid", {31'b0, out_valid}, 1);
         chk("bp hold", {7'b0, out_z, out_carry, out_tag}, snap);
      end
      out_ready = 1'b1;
      drain("bp", 40);
      chk("bp delivered", pops, S + 1);

      // Reset with 3 ops in flight; an op offered during rst must wait until after it
      for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'(i), T'(8'hC0 + i));
      repeat (3) cycle();
      rst = 1'b1;
      send(16'h8000, 16'h8001, 1'b0, 8'hEE);
      cycle();
      rst = 1'b0;
      chk("post-rst out_valid", {31'b0, out_valid}, 0);
      drain("post-rst", 40);
      repeat (8) cycle();

      // Random stream with random out_ready
      rand_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) send(W'($urandom), W'($urandom), 1'($urandom), T'($urandom));
      drain("random", 60000);
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
